// File: rtl/fft_reorder_ctrl.sv
// Ping-pong bit-reversal reorder controller: writes FFT frames into two external RAM
// banks in natural order and drains them in bit-reversed order through a skid-free output register.
module fft_reorder_ctrl #(
   parameter int N_LOG2 = 6,
   parameter int DW     = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   input  logic [DW-1:0]     in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DW-1:0]     out_data,
   input  logic              out_ready,
   output logic              out_last,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [N_LOG2-1:0] wr_addr,
   output logic [DW-1:0]     wr_data,
   output logic              rd_en,
   output logic              rd_bank,
   output logic [N_LOG2-1:0] rd_addr,
   input  logic [DW-1:0]     ram_rdata0,
   input  logic [DW-1:0]     ram_rdata1,
   output logic [15:0]       frames_out
);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

   localparam logic [N_LOG2-1:0] CNT_LAST = '1;

   bank_state_e       bank_q [2];
   bank_state_e       bank_d [2];
   logic              wsel_q, wsel_d, rsel_q, rsel_d;
   logic [N_LOG2-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
   logic              out_valid_q, out_valid_d;
   logic              rd_bank_q, rd_bank_d;
   logic              last_q, last_d;
   logic [15:0]       frames_q, frames_d;
   logic              accept, drain_active, rd_go;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
      return r;
   endfunction

   assign in_ready = (bank_q[wsel_q] == EMPTY) || (bank_q[wsel_q] == FILLING);
   assign accept   = in_valid & in_ready;

   // A FULL bank is read in the very next cycle, so FULL counts as draining for the read strobe.
   assign drain_active = (bank_q[rsel_q] == FULL) || (bank_q[rsel_q] == DRAINING);
   assign rd_go        = drain_active & (!out_valid_q | out_ready);

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
      bank_d      = bank_q;
      wsel_d      = wsel_q;
      rsel_d      = rsel_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      rd_bank_d   = rd_bank_q;
      last_d      = last_q;
      frames_d    = frames_q;
      out_valid_d = rd_go | (out_valid_q & !out_ready);

      if (accept) begin
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_q == CNT_LAST) begin
            bank_d[wsel_q] = FULL;
            wsel_d         = !wsel_q;
         end else begin
            bank_d[wsel_q] = FILLING;
         end
      end

      // Write and read always target different banks, so both updates can land on the same edge.
      if (rd_go) begin
         rcnt_d    = rcnt_q + 1'b1;
         rd_bank_d = rsel_q;
         last_d    = (rcnt_q == CNT_LAST);
         if (rcnt_q == CNT_LAST) begin
            bank_d[rsel_q] = EMPTY;
            rsel_d         = !rsel_q;
         end else begin
            bank_d[rsel_q] = DRAINING;
         end
      end

      if (out_valid_q && out_ready && last_q) frames_d = frames_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         bank_q      <= '{EMPTY, EMPTY};
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         out_valid_q <= 1'b0;
         rd_bank_q   <= 1'b0;
         last_q      <= 1'b0;
         frames_q    <= '0;
      end else begin
         bank_q      <= bank_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         out_valid_q <= out_valid_d;
         rd_bank_q   <= rd_bank_d;
         last_q      <= last_d;
         frames_q    <= frames_d;
      end
   end

   assign wr_en      = accept;
   assign wr_bank    = wsel_q;
   assign wr_addr    = wcnt_q;
   assign wr_data    = in_data;
   assign rd_en      = rd_go;
   assign rd_bank    = rsel_q;
   assign rd_addr    = bitrev(rcnt_q);
   assign out_valid  = out_valid_q;
   assign out_last   = out_valid_q & last_q;
   assign out_data   = rd_bank_q ? ram_rdata1 : ram_rdata0;
   assign frames_out = frames_q;

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Bench for fft_reorder_ctrl: two-bank RAM model, frame-level bit-reversal scoreboard,
// per-cycle protocol checks and directed/random scenarios.
module tb_fft_reorder_ctrl;
   localparam int N_LOG2 = 6;
   localparam int N      = 64;
   localparam int DW     = 32;
   localparam int LOGSZ  = 2048;

   logic              clk = 1'b0;
   logic              nrst;
   logic              in_valid;
   logic [DW-1:0]     in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_ready;
   logic              out_last;
   logic              wr_en, wr_bank, rd_en, rd_bank;
   logic [N_LOG2-1:0] wr_addr, rd_addr;
   logic [DW-1:0]     wr_data;
   logic [DW-1:0]     ram_rdata0, ram_rdata1;
   logic [15:0]       frames_out;

   always #5 clk = ~clk;

   fft_reorder_ctrl #(.N_LOG2(N_LOG2), .DW(DW)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .ram_rdata0(ram_rdata0), .ram_rdata1(ram_rdata1),
      .frames_out(frames_out)
   );

   // External RAM banks: 1W + 1R, one-cycle read latency, read data holds when not read.
   logic [DW-1:0] mem0 [N];
   logic [DW-1:0] mem1 [N];
   always @(posedge clk) begin
      if (wr_en && !wr_bank) mem0[wr_addr] <= wr_data;
      if (wr_en &&  wr_bank) mem1[wr_addr] <= wr_data;
      if (rd_en && !rd_bank) ram_rdata0 <= mem0[rd_addr];
      if (rd_en &&  rd_bank) ram_rdata1 <= mem1[rd_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int bitrev(input int v);
      int r = 0;
      for (int i = 0; i < N_LOG2; i++) r = r * 2 + ((v >> i) & 1);
      return r;
   endfunction

   // Behavioural model: collect whole frames, emit them bit-reversed in frame order.
   typedef struct {
      logic [DW-1:0] d;
      logic          last;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] part_q [$];
   int            m_wcnt = 0, m_frames_in = 0, m_frames_out = 0;
   int            cyc = 0, frame_done_cyc = 0, xfer_total = 0, rdy_low_total = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic [DW-1:0] log_data [LOGSZ];
   int            log_cyc  [LOGSZ];

   always @(negedge clk) begin
      cyc++;
      if (!nrst) begin
         exp_q.delete();
         part_q.delete();
         m_wcnt       = 0;
         m_frames_in  = 0;
         m_frames_out = 0;
         prev_stall   = 1'b0;
      end else begin
         if (!in_ready) rdy_low_total++;
         chk("frames_out", 64'(frames_out), 64'(m_frames_out % 65536));
         chk("wr_en", 64'(wr_en), 64'(in_valid & in_ready));
         if (wr_en && rd_en) chk("bank_overlap", 64'(wr_bank != rd_bank), 64'(1));
         if (in_valid && in_ready) begin
            chk("wr_addr", 64'(wr_addr), 64'(m_wcnt));
            chk("wr_bank", 64'(wr_bank), 64'(m_frames_in % 2));
            chk("wr_data", 64'(wr_data), 64'(in_data));
            part_q.push_back(in_data);
            m_wcnt++;
            if (m_wcnt == N) begin
               for (int k = 0; k < N; k++) begin
                  exp_t e;
                  e.d    = part_q[bitrev(k)];
                  e.last = (k == N - 1);
                  exp_q.push_back(e);
               end
               part_q.delete();
               m_wcnt = 0;
               m_frames_in++;
               frame_done_cyc = cyc;
            end
         end
         if (out_valid) begin
            if (!out_ready) chk("rd_en_stall", 64'(rd_en), 64'(0));
            if (exp_q.size() == 0) begin
               chk("out_unexpected", 64'(out_valid), 64'(0));
            end else begin
               chk("out_data", 64'(out_data), 64'(exp_q[0].d));
               chk("out_last", 64'(out_last), 64'(exp_q[0].last));
               if (prev_stall) chk("stall_stable", 64'(out_data), 64'(prev_data));
               if (out_ready) begin
                  log_data[xfer_total % LOGSZ] = out_data;
                  log_cyc[xfer_total % LOGSZ]  = cyc;
                  xfer_total++;
                  if (exp_q[0].last) m_frames_out++;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("out_last_idle", 64'(out_last), 64'(0));
            if (prev_stall) chk("valid_dropped", 64'(out_valid), 64'(1));
         end
         prev_stall = out_valid & !out_ready;
         prev_data  = out_data;
      end
   end

   // Consumer: 0 = always ready, 1 = random 50%, 2 = held off.
   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic send(input logic [DW-1:0] d);
      logic acc;
      int   b = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         b++;
      end while (!acc && b < 2000);
      if (!acc) chk("send_timeout", 64'(acc), 64'(1));
   endtask

   task automatic wait_out(input int target, input int budget);
      int b = 0;
      while (xfer_total < target && b < budget) begin
         @(posedge clk);
         b++;
      end
      #1;
      if (xfer_total < target) chk("drain_timeout", 64'(xfer_total), 64'(target));
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      nrst     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      logic [15:0] f0;
      int          r0;

      nrst      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      chk("bitrev_model", 64'(bitrev(1)), 64'(32));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_rd_en", 64'(rd_en), 64'(0));
      chk("rst_frames", 64'(frames_out), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      nrst = 1'b1;

      // Single frame 0..63
      base = xfer_total;
      for (int i = 0; i < N; i++) send(DW'(i));
      in_valid = 1'b0;
      wait_out(base + N, 400);
      chk("f1_out0", 64'(log_data[base % LOGSZ]), 64'(0));
      chk("f1_out1", 64'(log_data[(base + 1) % LOGSZ]), 64'(32));
      chk("f1_out2", 64'(log_data[(base + 2) % LOGSZ]), 64'(16));
      chk("f1_out3", 64'(log_data[(base + 3) % LOGSZ]), 64'(48));
      chk("f1_out4", 64'(log_data[(base + 4) % LOGSZ]), 64'(8));
      chk("f1_out5", 64'(log_data[(base + 5) % LOGSZ]), 64'(40));
      chk("f1_out63", 64'(log_data[(base + 63) % LOGSZ]), 64'(63));
      chk("f1_latency", 64'(log_cyc[base % LOGSZ] - frame_done_cyc), 64'(2));
      chk("f1_frames", 64'(frames_out), 64'(1));

      // Four back-to-back frames at full rate
      base = xfer_total;
      f0   = frames_out;
      r0   = rdy_low_total;
      for (int i = 0; i < 4 * N; i++) send(DW'(1000 + i));
      in_valid = 1'b0;
      wait_out(base + 4 * N, 1000);
      chk("b2b_in_ready_low_cycles", 64'(rdy_low_total - r0), 64'(0));
      chk("b2b_no_gaps", 64'(log_cyc[(base + 255) % LOGSZ] - log_cyc[base % LOGSZ]), 64'(255));
      chk("b2b_frames", 64'(16'(frames_out - f0)), 64'(4));

      // Random consumer stalls and random input gaps over three frames
      rdy_mode = 1;
      base     = xfer_total;
      f0       = frames_out;
      for (int i = 0; i < 3 * N; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send($urandom);
      end
      in_valid = 1'b0;
      wait_out(base + 3 * N, 3000);
      rdy_mode = 0;
      chk("rnd_frames", 64'(16'(frames_out - f0)), 64'(3));
      chk("rnd_exp_empty", 64'(exp_q.size()), 64'(0));

      // Consumer held off: both banks fill, input back-pressured
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      base = xfer_total;
      for (int i = 0; i < 2 * N; i++) send(DW'(2000 + i));
      chk("bp_in_ready_after_128", 64'(in_ready), 64'(0));
      in_data = 32'hDEAD_BEEF;
      repeat (4) @(posedge clk);
      #1;
      chk("bp_in_ready_held", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      rdy_mode = 0;
      wait_out(base + 2 * N, 600);
      chk("bp_in_ready_release", 64'(in_ready), 64'(1));
      chk("bp_first", 64'(log_data[base % LOGSZ]), 64'(2000));
      chk("bp_second_frame_first", 64'(log_data[(base + N) % LOGSZ]), 64'(2064));

      // Reset mid-frame and mid-drain
      for (int i = 0; i < 20; i++) send(DW'(3000 + i));
      do_reset();
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_frames", 64'(frames_out), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
      base = xfer_total;
      for (int i = 0; i < N; i++) send(DW'(4000 + i));
      in_valid = 1'b0;
      wait_out(base + 10, 200);
      do_reset();
      chk("drain_rst_out_valid", 64'(out_valid), 64'(0));
      chk("drain_rst_rd_en", 64'(rd_en), 64'(0));
      chk("drain_rst_frames", 64'(frames_out), 64'(0));
      chk("drain_rst_in_ready", 64'(in_ready), 64'(1));
      base = xfer_total;
      for (int i = 0; i < N; i++) send(DW'(100 + i));
      in_valid = 1'b0;
      wait_out(base + N, 400);
      chk("post_rst_out0", 64'(log_data[base % LOGSZ]), 64'(100));
      chk("post_rst_out1", 64'(log_data[(base + 1) % LOGSZ]), 64'(132));
      chk("post_rst_out63", 64'(log_data[(base + 63) % LOGSZ]), 64'(163));
      chk("post_rst_frames", 64'(frames_out), 64'(1));

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
